// File: rtl/gray2rgb_stream.sv
// -----------------------------------------------------------------------------
// gray2rgb_stream
//   Converts an 8-bit gray pixel stream into a 24-bit {R,G,B} stream. The input
//   carries start-of-frame and end-of-line flags. A small frame tracker follows
//   the geometry and flags length errors.
//
//   The pixel mapping is chosen by mode:
//     00: gray replicated to R, G and B
//     01: inverted gray replicated to R, G and B
//     10: pure red at or above thresh, otherwise gray
//     11: white at or above thresh, otherwise black
//
// Parameters
//   IMG_W      pixels per line
//   IMG_H      lines per frame
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   s_valid    input stream valid
//   s_ready    input stream ready
//   s_data     input gray pixel (8 bits)
//   s_sof      input start-of-frame flag
//   s_eol      input end-of-line flag
//   m_valid    output stream valid
//   m_ready    output stream ready
//   m_data     output pixel {R,G,B}
//   m_sof      output start-of-frame flag
//   m_eol      output end-of-line flag
//   mode       mapping select; latched on each accepted SOF pixel
//   thresh     compare threshold; latched on each accepted SOF pixel
//   frame_done one-cycle pulse when the last pixel of a frame leaves the block
//   err_len    sticky line-length / framing error flag
// -----------------------------------------------------------------------------
module gray2rgb_stream #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_sof,
  input  logic        s_eol,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [23:0] m_data,
  output logic        m_sof,
  output logic        m_eol,
  input  logic [1:0]  mode,
  input  logic [7:0]  thresh,
  output logic        frame_done,
  output logic        err_len
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [COL_W-1:0] r_col;
  logic [COL_W-1:0] w_col_next;
  logic [COL_W-1:0] w_pix_col;
  logic [ROW_W-1:0] r_row;
  logic [ROW_W-1:0] w_row_next;
  logic [ROW_W-1:0] w_pix_row;
  logic [1:0]       r_mode;
  logic [7:0]       r_thresh;
  logic             r_err;

  logic             w_en;
  logic             w_accept;
  logic             w_pass;
  logic             w_last;
  logic             w_err_evt;

  // Stage 1: registered input pixel plus the configuration that applies to it.
  logic             r_v1;
  logic [7:0]       r_data1;
  logic             r_sof1;
  logic             r_eol1;
  logic             r_last1;
  logic [1:0]       r_mode1;
  logic [7:0]       r_thresh1;

  // Stage 2: registered mapped output.
  logic             r_v2;
  logic [23:0]      r_data2;
  logic             r_sof2;
  logic             r_eol2;
  logic             r_last2;

  logic             w_above;
  logic [2:0][7:0]  w_map;

  // The whole pipeline advances together. It stalls only when the output
  // register holds a pixel that the sink has not taken yet.
  assign w_en     = !r_v2 || m_ready;
  assign s_ready  = w_en;
  assign w_accept = s_valid && w_en;

  // Frame tracker: next-state, counters and error detection.
  // A SOF pixel is always treated as position (0,0), whatever the counters
  // held before, so that a mid-frame SOF restarts the frame cleanly.
  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_pix_col    = s_sof ? '0 : r_col;
    w_pix_row    = s_sof ? '0 : r_row;
    w_pass       = 1'b0;
    w_last       = 1'b0;
    w_err_evt    = 1'b0;

    if (w_accept && (s_sof || (r_state == ST_ACTIVE))) begin
      w_pass       = 1'b1;
      w_state_next = ST_ACTIVE;

      if (s_sof && (r_state == ST_ACTIVE)) begin
        w_err_evt = 1'b1;
      end
      // Covers both an early eol and an eol missing at the last column.
      if (s_eol != (w_pix_col == COL_LAST)) begin
        w_err_evt = 1'b1;
      end

      // The line ends on the eol flag, or on reaching the last column when
      // eol is missing.
      if (s_eol || (w_pix_col == COL_LAST)) begin
        w_col_next = '0;
        w_row_next = w_pix_row + ROW_W'(1);
      end else begin
        w_col_next = w_pix_col + COL_W'(1);
      end

      if (s_eol && (w_pix_col == COL_LAST) && (w_pix_row == ROW_LAST)) begin
        w_last       = 1'b1;
        w_state_next = ST_IDLE;
        w_col_next   = '0;
        w_row_next   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_col    <= '0;
      r_row    <= '0;
      r_mode   <= 2'b00;
      r_thresh <= 8'h80;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
      if (w_accept && s_sof) begin
        r_mode   <= mode;
        r_thresh <= thresh;
      end
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  // Per-channel mapping. Channel 2 is R: it is the only channel lit in the
  // red-highlight mode.
  assign w_above = (r_data1 >= r_thresh1);

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    localparam logic [7:0] HOT = (gi == 2) ? 8'hFF : 8'h00;
    assign w_map[gi] = (r_mode1 == 2'b00) ? r_data1 :
                       (r_mode1 == 2'b01) ? ~r_data1 :
                       (r_mode1 == 2'b10) ? (w_above ? HOT : r_data1) :
                                            (w_above ? 8'hFF : 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1      <= 1'b0;
      r_data1   <= '0;
      r_sof1    <= 1'b0;
      r_eol1    <= 1'b0;
      r_last1   <= 1'b0;
      r_mode1   <= 2'b00;
      r_thresh1 <= 8'h80;
      r_v2      <= 1'b0;
      r_data2   <= '0;
      r_sof2    <= 1'b0;
      r_eol2    <= 1'b0;
      r_last2   <= 1'b0;
    end else if (w_en) begin
      r_v1    <= w_pass;
      r_data1 <= s_data;
      // Flags are qualified so that they read 0 on bubbles.
      r_sof1  <= s_sof && w_pass;
      r_eol1  <= s_eol && w_pass;
      r_last1 <= w_last;
      // The SOF pixel itself already uses the configuration that it latches.
      r_mode1   <= (w_accept && s_sof) ? mode   : r_mode;
      r_thresh1 <= (w_accept && s_sof) ? thresh : r_thresh;

      r_v2    <= r_v1;
      r_data2 <= w_map;
      r_sof2  <= r_sof1;
      r_eol2  <= r_eol1;
      r_last2 <= r_last1;
    end
  end

  assign m_valid    = r_v2;
  assign m_data     = r_data2;
  assign m_sof      = r_sof2;
  assign m_eol      = r_eol2;
  assign frame_done = r_v2 && m_ready && r_last2;
  assign err_len    = r_err;

endmodule

// File: doc/gray2rgb_stream.md
GRAY2RGB_STREAM -- requirements
Module: gray2rgb_stream

Interface
REQ-001 The block SHALL have parameter IMG_W, default 640, meaning pixels per line.
REQ-002 The block SHALL have parameter IMG_H, default 480, meaning lines per frame.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports s_valid (in, 1), s_ready (out, 1), s_data (in, 8), s_sof (in, 1), s_eol (in, 1), carrying the input gray pixel stream with start-of-frame and end-of-line flags.
REQ-006 The block SHALL have ports m_valid (out, 1), m_ready (in, 1), m_data (out, 24, {R,G,B}), m_sof (out, 1), m_eol (out, 1), carrying the output RGB888 stream.
REQ-007 The block SHALL have inputs mode (2 bits) and thresh (8 bits) as configuration, plus outputs frame_done (1 bit, pulse) and err_len (1 bit, sticky).

Function
REQ-008 A transfer SHALL occur on either side only in a cycle where valid and ready are both 1.
REQ-009 Pixel mapping SHALL be: mode 00 -> {g,g,g}; mode 01 -> {~g,~g,~g}; mode 10 -> 24'hFF0000 if g>=thresh, else {g,g,g}; mode 11 -> 24'hFFFFFF if g>=thresh, else 24'h000000.
REQ-010 The threshold compare SHALL be unsigned 8-bit; the g==thresh case counts as "at or above".
REQ-011 mode and thresh SHALL be latched on the accepted SOF pixel and held for the whole frame; mid-frame changes SHALL have no effect until the next SOF.
REQ-012 The datapath SHALL be a 2-stage pipeline (S1 registered input, S2 registered mapped output) with a global advance enable en = !v2 | m_ready.
REQ-013 s_ready SHALL equal en; this combinational path from m_ready is permitted.
REQ-014 With m_ready held at 1, m_valid SHALL assert exactly 2 cycles after the input handshake, and throughput SHALL be 1 pixel per cycle.
REQ-015 While m_valid=1 and m_ready=0, m_data, m_sof and m_eol SHALL hold stable and no input SHALL be accepted.
REQ-016 m_sof and m_eol SHALL be the s_sof and s_eol of the same pixel, delayed with it.
REQ-017 The FSM SHALL have states IDLE and ACTIVE.
REQ-018 In IDLE, accepted pixels with s_sof=0 SHALL be discarded without output; an accepted pixel with s_sof=1 SHALL be passed through and move the FSM to ACTIVE with col=1, row=0.
REQ-019 In ACTIVE, each accepted pixel SHALL increment col (width ceil(log2(IMG_W)) bits). On an accepted pixel with s_eol=1, col SHALL clear and row SHALL increment.
REQ-020 err_len SHALL set and stay set until reset on any of these events:
- s_eol=1 with col != IMG_W-1;
- a pixel at col == IMG_W-1 with s_eol=0;
- s_sof=1 while in ACTIVE.
REQ-021 On a bad s_eol, col/row SHALL still follow the s_eol flag. A missing eol SHALL wrap col to 0 and increment row.
REQ-022 A SOF arriving while in ACTIVE SHALL restart the counters (col=1, row=0) and latch new config.
REQ-023 When the pixel at row IMG_H-1, col IMG_W-1 (s_eol=1) is accepted, the FSM SHALL return to IDLE.
REQ-024 frame_done SHALL pulse for 1 cycle when that last pixel transfers on the output side.
REQ-025 Simultaneous input accept and output transfer in the same cycle SHALL not lose or duplicate data.

Reset
REQ-026 While rst_n=0, the block SHALL hold these values:
- v1, v2, m_valid, m_sof, m_eol, frame_done, err_len = 0;
- m_data = 0;
- col, row = 0;
- FSM = IDLE;
- latched mode = 00, latched thresh = 8'h80.
REQ-027 Reset asserted mid-frame SHALL drop all in-flight pixels. After release, the block SHALL discard input until the next SOF.
REQ-028 s_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-029 The bench SHALL cover mode 00, g=8'h5A, m_ready=1: m_data=24'h5A5A5A, m_valid exactly 2 cycles after the handshake.
REQ-030 The bench SHALL cover mode 10, thresh=8'h80, pixels 8'h7F and 8'h80: outputs 24'h7F7F7F, then 24'hFF0000.
REQ-031 The bench SHALL cover backpressure with m_ready=0 for 5 cycles mid-stream: m_data held stable, s_ready=0 after the pipeline fills, no pixel lost or duplicated, order preserved.
REQ-032 The bench SHALL cover a full IMG_W=4, IMG_H=2 frame in mode 11 with thresh=8'h10: frame_done pulses once with the 8th output, err_len=0, FSM back in IDLE.
REQ-033 The bench SHALL cover s_eol at col 2 with IMG_W=4: err_len=1 and remains 1 through later good frames until rst_n=0.
REQ-034 The bench SHALL cover rst_n low for 1 cycle mid-frame: all outputs take reset values, pre-SOF pixels are discarded, and the next SOF pixel is the first output.
